adc_trigger: RTL and testbench

//   Generates trigger_req for adc_controller from the filtered ADC sample stream.
//   - Edge trigger on a programmable level, with slope select and hysteresis.
//   - Auto-timeout mode, external trigger input, software force and post-fire holdoff.
//   - Sits between the ADC filter and adc_controller.
//   - Configuration comes from SPI-written registers; trig_status is read back over SPI.

---
 rtl/adc_trigger_pkg.sv | 35 +++
 rtl/adc_trigger_sync_edge.sv | 22 ++
 rtl/adc_trigger.sv | 146 ++++++++++++++
 tb/tb_adc_trigger.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_trigger_pkg.sv
// Shared encodings for the ADC trigger block: modes, slope, fire source and FSM states.
package adc_trigger_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int HOLD_W_DEF = 16;
    localparam int AUTO_W_DEF = 20;

    typedef enum logic [1:0] {
        TRIG_OFF    = 2'd0,
        TRIG_NORMAL = 2'd1,
        TRIG_AUTO   = 2'd2,
        TRIG_EXT    = 2'd3
    } trig_mode_e;

    typedef enum logic {
        SLOPE_RISE = 1'b0,
        SLOPE_FALL = 1'b1
    } trig_slope_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EDGE = 2'd1,
        SRC_AUTO = 2'd2,
        SRC_EXT  = 2'd3
    } trig_src_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREARM = 3'd1,
        ST_READY  = 3'd2,
        ST_FIRE   = 3'd3,
        ST_HOLD   = 3'd4
    } trig_state_e;

endpackage

// File: rtl/adc_trigger_sync_edge.sv
// Two-flop synchronizer for the external trigger pin plus a delayed copy for rising-edge detect.
module adc_trigger_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    // Only the settled stages feed the edge detect; stage 0 may be metastable.
    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/adc_trigger.sv
// Trigger generator for adc_controller: level/slope edge trigger with hysteresis pre-arm,
// auto timeout, external trigger, software force and post-fire holdoff.
//
// state  | meaning
// IDLE   | disarmed, waiting for arm with a non-off mode
// PREARM | armed, waiting for a sample on the far side of the hysteresis band
// READY  | pre-armed, waiting for a level crossing
// FIRE   | trigger_req high for this one clock
// HOLD   | ignoring samples until holdoff strobes have passed
module adc_trigger
    import adc_trigger_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int AUTO_W = AUTO_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic [1:0]        mode,
    input  logic              slope,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] hyst,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic [AUTO_W-1:0] auto_to,
    input  logic              ext_trig,
    input  logic              force_req,
    output logic              trigger_req,
    output logic [1:0]        trig_status
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [AUTO_W-1:0] AUTO_ONE = AUTO_W'(1);

    trig_state_e       state;
    logic [AUTO_W-1:0] auto_ctr;
    logic [HOLD_W-1:0] hold_ctr;

    logic              ext_rise;
    logic [DATA_W:0]   lvl_minus;
    logic [DATA_W:0]   lvl_plus;
    logic [DATA_W-1:0] thr_lo;
    logic [DATA_W-1:0] thr_hi;
    logic              qualify;
    logic              crossing;
    logic [AUTO_W-1:0] auto_next;
    logic              edge_fire;
    logic              auto_fire;
    logic              ext_fire;
    logic              fire_now;
    trig_src_e         fire_src;

    adc_trigger_sync_edge u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (ext_trig),
        .rise     (ext_rise)
    );

    // One extra bit catches underflow of level-hyst and overflow of level+hyst.
    assign lvl_minus = {1'b0, level} - {1'b0, hyst};
    assign lvl_plus  = {1'b0, level} + {1'b0, hyst};
    assign thr_lo    = lvl_minus[DATA_W] ? '0 : lvl_minus[DATA_W-1:0];
    assign thr_hi    = lvl_plus[DATA_W]  ? '1 : lvl_plus[DATA_W-1:0];

    assign qualify   = (slope == SLOPE_FALL) ? (adc_data >= thr_hi) : (adc_data <= thr_lo);
    assign crossing  = (slope == SLOPE_FALL) ? (adc_data <= level)  : (adc_data >= level);

    assign auto_next = (&auto_ctr) ? auto_ctr : auto_ctr + AUTO_ONE;

    assign edge_fire = (state == ST_READY) && sample_en && crossing &&
                       ((mode == TRIG_NORMAL) || (mode == TRIG_AUTO));
    assign auto_fire = (mode == TRIG_AUTO) && sample_en && (auto_next >= auto_to);
    assign ext_fire  = (mode == TRIG_EXT) && ext_rise;

    // Force and external win over a simultaneous edge so the source is reported as ext/force.
    always_comb begin
        fire_now = 1'b1;
        fire_src = SRC_EXT;
        if (force_req || ext_fire) begin
            fire_src = SRC_EXT;
        end else if (edge_fire) begin
            fire_src = SRC_EDGE;
        end else if (auto_fire) begin
            fire_src = SRC_AUTO;
        end else begin
            fire_now = 1'b0;
            fire_src = SRC_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            trigger_req <= 1'b0;
            trig_status <= SRC_NONE;
            auto_ctr    <= '0;
            hold_ctr    <= '0;
        end else begin
            trigger_req <= 1'b0;
            if (mode == TRIG_OFF) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm) begin
                            state    <= ST_PREARM;
                            auto_ctr <= '0;
                        end
                    end
                    ST_PREARM, ST_READY: begin
                        if (!arm) begin
                            state <= ST_IDLE;
                        end else if (fire_now) begin
                            state       <= ST_FIRE;
                            trigger_req <= 1'b1;
                            trig_status <= fire_src;
                        end else if (sample_en) begin
                            auto_ctr <= auto_next;
                            if ((state == ST_PREARM) && qualify) begin
                                state <= ST_READY;
                            end
                        end
                    end
                    ST_FIRE: begin
                        hold_ctr <= '0;
                        state    <= (holdoff != '0) ? ST_HOLD : ST_IDLE;
                    end
                    ST_HOLD: begin
                        if (sample_en) begin
                            if (hold_ctr == holdoff - HOLD_ONE) begin
                                state <= ST_IDLE;
                            end else begin
                                hold_ctr <= hold_ctr + HOLD_ONE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_trigger.sv
// Directed-vector bench for adc_trigger: edge, saturated thresholds, auto, holdoff, force, ext, reset.
module tb_adc_trigger;
    import adc_trigger_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic [9:0]  adc_data;
    logic        arm;
    logic [1:0]  mode;
    logic        slope;
    logic [9:0]  level;
    logic [9:0]  hyst;
    logic [15:0] holdoff;
    logic [19:0] auto_to;
    logic        ext_trig;
    logic        force_req;
    logic        trigger_req;
    logic [1:0]  trig_status;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    logic last_fire;

    adc_trigger dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .adc_data    (adc_data),
        .arm         (arm),
        .mode        (mode),
        .slope       (slope),
        .level       (level),
        .hyst        (hyst),
        .holdoff     (holdoff),
        .auto_to     (auto_to),
        .ext_trig    (ext_trig),
        .force_req   (force_req),
        .trigger_req (trigger_req),
        .trig_status (trig_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (trigger_req) pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One strobe; last_fire holds trigger_req one clock after the strobe edge.
    task automatic send(input logic [9:0] v);
        @(negedge clk);
        adc_data  = v;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        last_fire = trigger_req;
        @(negedge clk);
    endtask

    task automatic arm_up();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (trigger_req !== 1'b0) begin bad++; $display("FAIL reset_trig: got=%0d want=0", trigger_req); end
        total++; if (trig_status !== 2'd0) begin bad++; $display("FAIL reset_status: got=%0d want=0", trig_status); end
        total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got=%0d want=%0d", dut.state, ST_IDLE); end
        total++; if (dut.auto_ctr !== 20'd0) begin bad++; $display("FAIL reset_auto_ctr: got=%0d want=0", dut.auto_ctr); end
        total++; if (dut.hold_ctr !== 16'd0) begin bad++; $display("FAIL reset_hold_ctr: got=%0d want=0", dut.hold_ctr); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rising();
        int p0;
        mode = 2'd1; slope = 1'b0; level = 10'd512; hyst = 10'd16; holdoff = 16'd0;
        p0 = pulses;
        send(10'd400); send(10'd520); send(10'd600);
        arm_up();
        send(10'd520); send(10'd600);
        total++; if (pulses !== p0) begin bad++; $display("FAIL rise_noprearm: pulses=%0d want=%0d", pulses, p0); end
        total++; if (dut.state !== ST_PREARM) begin bad++; $display("FAIL rise_prearm_state: got=%0d want=%0d", dut.state, ST_PREARM); end
        send(10'd490);
        total++; if (dut.state !== ST_READY) begin bad++; $display("FAIL rise_ready: got=%0d want=%0d", dut.state, ST_READY); end
        send(10'd513);
        arm = 1'b0;
        total++; if (last_fire !== 1'b1) begin bad++; $display("FAIL rise_fire: got=%0d want=1", last_fire); end
        total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL rise_pulses: got=%0d want=%0d", pulses, p0 + 1); end
        total++; if (trig_status !== 2'd1) begin bad++; $display("FAIL rise_status: got=%0d want=1", trig_status); end
        total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL rise_idle: got=%0d want=%0d", dut.state, ST_IDLE); end
    endtask

    task automatic test_saturation();
        int p0;
        mode = 2'd1; slope = 1'b1; level = 10'd100; hyst = 10'd200;
        arm_up();
        send(10'd299);
        total++; if (dut.state !== ST_PREARM) begin bad++; $display("FAIL fall_hi300_below: got=%0d want=%0d", dut.state, ST_PREARM); end
        send(10'd300);
        total++; if (dut.state !== ST_READY) begin bad++; $display("FAIL fall_hi300_at: got=%0d want=%0d", dut.state, ST_READY); end
        send(10'd99);
        arm = 1'b0;
        total++; if (last_fire !== 1'b1) begin bad++; $display("FAIL fall_fire: got=%0d want=1", last_fire); end

        slope = 1'b0;
        arm_up();
        send(10'd1);
        total++; if (dut.state !== ST_PREARM) begin bad++; $display("FAIL rise_lo_clamp1: got=%0d want=%0d", dut.state, ST_PREARM); end
        send(10'd0);
        total++; if (dut.state !== ST_READY) begin bad++; $display("FAIL rise_lo_clamp0: got=%0d want=%0d", dut.state, ST_READY); end
        send(10'd150);
        arm = 1'b0;
        total++; if (last_fire !== 1'b1) begin bad++; $display("FAIL rise_lo_fire: got=%0d want=1", last_fire); end

        slope = 1'b1; level = 10'd1000; hyst = 10'd100;
        p0 = pulses;
        arm_up();
        send(10'd1022); send(10'd999);
        total++; if (pulses !== p0) begin bad++; $display("FAIL fall_hi1023_nofire: pulses=%0d want=%0d", pulses, p0); end
        send(10'd1023);
        total++; if (dut.state !== ST_READY) begin bad++; $display("FAIL fall_hi1023_at: got=%0d want=%0d", dut.state, ST_READY); end
        send(10'd999);
        arm = 1'b0;
        total++; if (last_fire !== 1'b1) begin bad++; $display("FAIL fall_hi1023_fire: got=%0d want=1", last_fire); end
    endtask

    task automatic test_auto();
        int p0;
        mode = 2'd2; slope = 1'b0; level = 10'd512; hyst = 10'd16; auto_to = 20'd5;
        p0 = pulses;
        arm_up();
        repeat (4) send(10'd0);
        total++; if (pulses !== p0) begin bad++; $display("FAIL auto_early: pulses=%0d want=%0d", pulses, p0); end
        send(10'd0);
        arm = 1'b0;
        total++; if (last_fire !== 1'b1) begin bad++; $display("FAIL auto_fire5: got=%0d want=1", last_fire); end
        total++; if (trig_status !== 2'd2) begin bad++; $display("FAIL auto_status: got=%0d want=2", trig_status); end
        p0 = pulses;
        send(10'd490); send(10'd513);
        total++; if (pulses !== p0) begin bad++; $display("FAIL auto_disarmed_edge: pulses=%0d want=%0d", pulses, p0); end
        arm_up();
        send(10'd490); send(10'd513);
        arm = 1'b0;
        total++; if (last_fire !== 1'b1) begin bad++; $display("FAIL auto_edge_fire: got=%0d want=1", last_fire); end
        total++; if (trig_status !== 2'd1) begin bad++; $display("FAIL auto_edge_status: got=%0d want=1", trig_status); end
        auto_to = 20'd0;
        arm_up();
        send(10'd600);
        arm = 1'b0;
        total++; if (last_fire !== 1'b1) begin bad++; $display("FAIL auto_zero: got=%0d want=1", last_fire); end
        total++; if (trig_status !== 2'd2) begin bad++; $display("FAIL auto_zero_status: got=%0d want=2", trig_status); end
        auto_to = 20'd1000;
    endtask

    task automatic test_holdoff();
        int p0;
        mode = 2'd1; slope = 1'b0; level = 10'd512; hyst = 10'd16; holdoff = 16'd3;
        arm_up();
        send(10'd490); send(10'd513);
        p0 = pulses;
        total++; if (dut.state !== ST_HOLD) begin bad++; $display("FAIL hold_enter: got=%0d want=%0d", dut.state, ST_HOLD); end
        send(10'd490); send(10'd513); send(10'd490);
        total++; if (pulses !== p0) begin bad++; $display("FAIL hold_nofire: pulses=%0d want=%0d", pulses, p0); end
        total++; if (dut.state !== ST_PREARM) begin bad++; $display("FAIL hold_exit: got=%0d want=%0d", dut.state, ST_PREARM); end
        send(10'd490); send(10'd513);
        total++; if (last_fire !== 1'b1) begin bad++; $display("FAIL hold_refire: got=%0d want=1", last_fire); end
        total++; if (dut.state !== ST_HOLD) begin bad++; $display("FAIL hold_reenter: got=%0d want=%0d", dut.state, ST_HOLD); end
        @(negedge clk);
        mode = 2'd0;
        arm = 1'b0;
        @(negedge clk);
        total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL hold_cancel: got=%0d want=%0d", dut.state, ST_IDLE); end
        holdoff = 16'd0;
    endtask

    task automatic test_force_ext();
        int p0;
        mode = 2'd1; slope = 1'b0; level = 10'd512; hyst = 10'd16;
        arm_up();
        send(10'd490);
        p0 = pulses;
        @(negedge clk);
        adc_data = 10'd513; sample_en = 1'b1; force_req = 1'b1;
        @(negedge clk);
        sample_en = 1'b0; force_req = 1'b0; arm = 1'b0;
        total++; if (trigger_req !== 1'b1) begin bad++; $display("FAIL force_fire: got=%0d want=1", trigger_req); end
        repeat (3) @(negedge clk);
        total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL force_once: pulses=%0d want=%0d", pulses, p0 + 1); end
        total++; if (trig_status !== 2'd3) begin bad++; $display("FAIL force_status: got=%0d want=3", trig_status); end

        mode = 2'd0; arm = 1'b1;
        p0 = pulses;
        @(negedge clk); force_req = 1'b1;
        @(negedge clk); force_req = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (pulses !== p0) begin bad++; $display("FAIL force_off: pulses=%0d want=%0d", pulses, p0); end
        arm = 1'b0;
        @(negedge clk);

        mode = 2'd3;
        arm_up();
        p0 = pulses;
        send(10'd490); send(10'd513);
        total++; if (pulses !== p0) begin bad++; $display("FAIL ext_ignores_level: pulses=%0d want=%0d", pulses, p0); end
        @(negedge clk);
        ext_trig = 1'b1;
        @(posedge clk); #1;
        total++; if (trigger_req !== 1'b0) begin bad++; $display("FAIL ext_clk1: got=%0d want=0", trigger_req); end
        @(posedge clk); #1;
        total++; if (trigger_req !== 1'b0) begin bad++; $display("FAIL ext_clk2: got=%0d want=0", trigger_req); end
        @(posedge clk); #1;
        total++; if (trigger_req !== 1'b1) begin bad++; $display("FAIL ext_clk3: got=%0d want=1", trigger_req); end
        total++; if (trig_status !== 2'd3) begin bad++; $display("FAIL ext_status: got=%0d want=3", trig_status); end
        @(negedge clk);
        arm = 1'b0; ext_trig = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        mode = 2'd1; slope = 1'b0; level = 10'd512; hyst = 10'd16;
        arm_up();
        send(10'd490);
        @(negedge clk);
        adc_data = 10'd513; sample_en = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        total++; if (trigger_req !== 1'b0) begin bad++; $display("FAIL rst_mid_trig: got=%0d want=0", trigger_req); end
        total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL rst_mid_state: got=%0d want=%0d", dut.state, ST_IDLE); end
        @(negedge clk);
        rst = 1'b0; sample_en = 1'b0;
        @(negedge clk);
        total++; if (dut.state !== ST_PREARM) begin bad++; $display("FAIL disarm_pre: got=%0d want=%0d", dut.state, ST_PREARM); end
        arm = 1'b0;
        @(posedge clk); #1;
        total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL disarm_idle: got=%0d want=%0d", dut.state, ST_IDLE); end
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; adc_data = '0; arm = 1'b0; mode = 2'd0;
        slope = 1'b0; level = '0; hyst = '0; holdoff = '0; auto_to = 20'd1000;
        ext_trig = 1'b0; force_req = 1'b0; last_fire = 1'b0;
        test_reset();
        test_rising();
        test_saturation();
        test_auto();
        test_holdoff();
        test_force_ext();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
